// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor: a - b - borrow_in, LSB first, one bit per clock.
// Define SERIAL_SUB_OVF_EN to add the signed-overflow output ovf.
module serial_subtractor #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             borrow_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             borrow
`ifdef SERIAL_SUB_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int unsigned CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  a_q, a_d;
    logic [WIDTH-1:0]  b_q, b_d;
    logic [WIDTH-1:0]  diff_q, diff_d;
    logic              br_q, br_d;
    logic              borrow_q, borrow_d;
    logic [CW-1:0]     cnt_q, cnt_d;
`ifdef SERIAL_SUB_OVF_EN
    logic              ovf_q, ovf_d;
`endif

    logic              bit_diff;
    logic              bit_borrow;

    // Single full-subtractor cell on the operand LSBs.
    always_comb begin
        bit_diff   = a_q[0] ^ b_q[0] ^ br_q;
        bit_borrow = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & br_q);
    end

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        diff_d   = diff_q;
        br_d     = br_q;
        borrow_d = borrow_q;
        cnt_d    = cnt_q;
`ifdef SERIAL_SUB_OVF_EN
        ovf_d    = ovf_q;
`endif
        in_ready  = (state_q == S_IDLE);
        out_valid = (state_q == S_DONE);

        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b;
                    br_d    = borrow_in;
                    cnt_d   = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                a_d    = a_q >> 1;
                b_d    = b_q >> 1;
                diff_d = {bit_diff, diff_q[WIDTH-1:1]};
                br_d   = bit_borrow;
                cnt_d  = cnt_q + CW'(1);
                if (cnt_q == LAST_BIT) begin
                    borrow_d = bit_borrow;
`ifdef SERIAL_SUB_OVF_EN
                    // Borrow into the MSB differing from borrow out of it flags signed overflow.
                    ovf_d    = br_q ^ bit_borrow;
`endif
                    state_d  = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            a_q      <= '0;
            b_q      <= '0;
            diff_q   <= '0;
            br_q     <= 1'b0;
            borrow_q <= 1'b0;
            cnt_q    <= '0;
`ifdef SERIAL_SUB_OVF_EN
            ovf_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            diff_q   <= diff_d;
            br_q     <= br_d;
            borrow_q <= borrow_d;
            cnt_q    <= cnt_d;
`ifdef SERIAL_SUB_OVF_EN
            ovf_q    <= ovf_d;
`endif
        end
    end

    assign diff   = diff_q;
    assign borrow = borrow_q;
`ifdef SERIAL_SUB_OVF_EN
    assign ovf    = ovf_q;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed bench for serial_subtractor: WIDTH=8 vector table and corner sequences, WIDTH=16 random stream.
module tb_serial_subtractor;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    logic       in_valid8 = 1'b0, in_ready8, out_valid8, out_ready8 = 1'b0;
    logic [7:0] a8 = '0, b8 = '0, diff8;
    logic       bin8 = 1'b0, borrow8;
`ifdef SERIAL_SUB_OVF_EN
    logic       ovf8;
`endif

    logic        in_valid16 = 1'b0, in_ready16, out_valid16, out_ready16 = 1'b0;
    logic [15:0] a16 = '0, b16 = '0, diff16;
    logic        bin16 = 1'b0, borrow16;
`ifdef SERIAL_SUB_OVF_EN
    logic        ovf16;
`endif

    serial_subtractor #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid8), .in_ready(in_ready8),
        .a(a8), .b(b8), .borrow_in(bin8),
        .out_valid(out_valid8), .out_ready(out_ready8),
        .diff(diff8), .borrow(borrow8)
`ifdef SERIAL_SUB_OVF_EN
        , .ovf(ovf8)
`endif
    );

    serial_subtractor #(.WIDTH(16)) dut16 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid16), .in_ready(in_ready16),
        .a(a16), .b(b16), .borrow_in(bin16),
        .out_valid(out_valid16), .out_ready(out_ready16),
        .diff(diff16), .borrow(borrow16)
`ifdef SERIAL_SUB_OVF_EN
        , .ovf(ovf16)
`endif
    );

    typedef struct packed {
        logic [7:0] a;
        logic [7:0] b;
        logic       bin;
        logic [7:0] d;
        logic       br;
        logic       ov;
    } vec_t;

    vec_t vecs[10];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic wait_ready8();
        int k = 0;
        while (!in_ready8 && k < 40) begin
            tick();
            k++;
        end
        check("in_ready8_wait", {31'd0, in_ready8}, 32'd1);
    endtask

    // Called just after the accepting edge; waits for the result and checks it.
    task automatic wait_result8(input string name, input logic [7:0] d, input logic br, input logic ov);
        int lat = 0;
        do begin
            tick();
            lat++;
            if (!out_valid8 && lat < 8) check({name, "_in_ready_run"}, {31'd0, in_ready8}, 32'd0);
        end while (!out_valid8 && lat < 40);
        check({name, "_latency"}, lat, 32'd8);
        check({name, "_diff"}, {24'd0, diff8}, {24'd0, d});
        check({name, "_borrow"}, {31'd0, borrow8}, {31'd0, br});
`ifdef SERIAL_SUB_OVF_EN
        check({name, "_ovf"}, {31'd0, ovf8}, {31'd0, ov});
`else
        if (ov === 1'bx) $display("unexpected X in vector table");
`endif
    endtask

    task automatic consume8(input string name);
        out_ready8 = 1'b1;
        tick();
        out_ready8 = 1'b0;
        check({name, "_out_valid_after"}, {31'd0, out_valid8}, 32'd0);
        check({name, "_in_ready_after"}, {31'd0, in_ready8}, 32'd1);
    endtask

    task automatic run_op8(input string name, input logic [7:0] a, input logic [7:0] b, input logic bin,
                           input logic [7:0] d, input logic br, input logic ov);
        wait_ready8();
        a8 = a; b8 = b; bin8 = bin; in_valid8 = 1'b1;
        tick();
        in_valid8 = 1'b0;
        wait_result8(name, d, br, ov);
        consume8(name);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vecs[0] = '{a: 8'h35, b: 8'h12, bin: 1'b0, d: 8'h23, br: 1'b0, ov: 1'b0};
        vecs[1] = '{a: 8'h00, b: 8'h01, bin: 1'b0, d: 8'hFF, br: 1'b1, ov: 1'b0};
        vecs[2] = '{a: 8'h10, b: 8'h0F, bin: 1'b1, d: 8'h00, br: 1'b0, ov: 1'b0};
        vecs[3] = '{a: 8'h5A, b: 8'h5A, bin: 1'b0, d: 8'h00, br: 1'b0, ov: 1'b0};
        vecs[4] = '{a: 8'h00, b: 8'hFF, bin: 1'b1, d: 8'h00, br: 1'b1, ov: 1'b0};
        vecs[5] = '{a: 8'hA5, b: 8'h5A, bin: 1'b0, d: 8'h4B, br: 1'b0, ov: 1'b1};
        vecs[6] = '{a: 8'hFF, b: 8'h00, bin: 1'b1, d: 8'hFE, br: 1'b0, ov: 1'b0};
        vecs[7] = '{a: 8'h80, b: 8'h01, bin: 1'b0, d: 8'h7F, br: 1'b0, ov: 1'b1};
        vecs[8] = '{a: 8'h7F, b: 8'hFF, bin: 1'b0, d: 8'h80, br: 1'b1, ov: 1'b1};
        vecs[9] = '{a: 8'h01, b: 8'h02, bin: 1'b1, d: 8'hFE, br: 1'b1, ov: 1'b0};

        // Reset state, with in_valid high to show nothing is captured.
        in_valid8 = 1'b1; a8 = 8'h77; b8 = 8'h11;
        tick();
        tick();
        check("rst_in_ready", {31'd0, in_ready8}, 32'd1);
        check("rst_out_valid", {31'd0, out_valid8}, 32'd0);
        check("rst_diff", {24'd0, diff8}, 32'd0);
        check("rst_borrow", {31'd0, borrow8}, 32'd0);
        in_valid8 = 1'b0;
        rst_n = 1'b1;
        tick();
        check("post_rst_in_ready", {31'd0, in_ready8}, 32'd1);

        // Vector table, with out_ready high while idle (must have no effect).
        out_ready8 = 1'b1;
        tick();
        check("idle_out_ready_out_valid", {31'd0, out_valid8}, 32'd0);
        out_ready8 = 1'b0;
        for (int i = 0; i < 10; i++) begin
            run_op8($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].bin,
                    vecs[i].d, vecs[i].br, vecs[i].ov);
        end

        // Result held in DONE while new operands are offered.
        wait_ready8();
        a8 = 8'h35; b8 = 8'h12; bin8 = 1'b0; in_valid8 = 1'b1;
        tick();
        a8 = 8'hFF; b8 = 8'h00; bin8 = 1'b0;
        wait_result8("hold", 8'h23, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("hold_out_valid", {31'd0, out_valid8}, 32'd1);
            check("hold_in_ready", {31'd0, in_ready8}, 32'd0);
            check("hold_diff", {24'd0, diff8}, 32'h23);
            check("hold_borrow", {31'd0, borrow8}, 32'd0);
        end
        consume8("hold");
        tick();
        in_valid8 = 1'b0;
        check("hold_next_accepted", {31'd0, in_ready8}, 32'd0);
        wait_result8("hold_next", 8'hFF, 1'b0, 1'b0);
        consume8("hold_next");

        // Reset in the middle of RUN.
        wait_ready8();
        a8 = 8'h35; b8 = 8'h12; bin8 = 1'b0; in_valid8 = 1'b1;
        tick();
        in_valid8 = 1'b0;
        tick(); tick(); tick();
        check("abort_in_run", {31'd0, in_ready8}, 32'd0);
        #1 rst_n = 1'b0;
        #1;
        check("abort_out_valid", {31'd0, out_valid8}, 32'd0);
        check("abort_diff", {24'd0, diff8}, 32'd0);
        check("abort_borrow", {31'd0, borrow8}, 32'd0);
        check("abort_in_ready", {31'd0, in_ready8}, 32'd1);
        @(posedge clk);
        #2 rst_n = 1'b1;
        run_op8("after_abort", 8'hA5, 8'h5A, 1'b0, 8'h4B, 1'b0, 1'b1);

        // Back-to-back stream on the 16-bit instance against an arithmetic model.
        in_valid16 = 1'b1;
        out_ready16 = 1'b1;
        begin
            int prev_acc = 0;
            for (int i = 0; i < 100; i++) begin
                logic [15:0] ea, eb;
                logic        ebin;
                logic [16:0] ref_res;
                int          k;
                int          lat;
                int          acc;
                k = 0;
                while (!in_ready16 && k < 40) begin
                    tick();
                    k++;
                end
                check("s16_in_ready", {31'd0, in_ready16}, 32'd1);
                ea = 16'($urandom);
                eb = 16'($urandom);
                ebin = 1'($urandom_range(0, 1));
                a16 = ea; b16 = eb; bin16 = ebin;
                ref_res = {1'b0, ea} - {1'b0, eb} - {16'd0, ebin};
                tick();
                acc = cyc;
                if (i > 0) check("s16_period", acc - prev_acc, 32'd18);
                prev_acc = acc;
                a16 = ~ea; b16 = ~eb; bin16 = ~ebin;
                lat = 0;
                do begin
                    tick();
                    lat++;
                end while (!out_valid16 && lat < 40);
                check("s16_latency", lat, 32'd16);
                check("s16_diff", {16'd0, diff16}, {16'd0, ref_res[15:0]});
                check("s16_borrow", {31'd0, borrow16}, {31'd0, ref_res[16]});
                tick();
            end
        end
        in_valid16 = 1'b0;
        out_ready16 = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
